logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit; successor to the fixed 1-bit combinational gate block.
- Applies one of eight selectable bitwise ops to WIDTH-bit operands.
- Two-stage registered pipeline with valid/ready flow control on both sides; accumulate mode chains results.
- Sits between an operand source and a result consumer in datapath/self-test logic.

---
 rtl/logic_unit_pkg.sv | 39 +++
 rtl/logic_unit_stage.sv | 28 ++
 rtl/logic_unit_pipe.sv | 116 +++++++++++
 tb/tb_logic_unit_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op encoding and per-bit op helper
// shared by the logic unit pipeline
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NAND   = 3'd2,
    OP_NOR    = 3'd3,
    OP_XOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  // one bit lane; the top replicates it across WIDTH
  function automatic logic apply_op(
    op_e  op,
    logic a,
    logic b
  );
    logic r;
    r = 1'b0;
    unique case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XOR:    r = a ^ b;
      OP_XNOR:   r = ~(a ^ b);
      OP_NOT_A:  r = ~a;
      OP_PASS_A: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// logic_unit_stage: generic valid/ready register slice
// ready passes through when the slice is empty or draining
module logic_unit_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit
// optional counters: define LOGIC_UNIT_PIPE_STATS_EN
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
`ifdef LOGIC_UNIT_PIPE_STATS_EN
  output logic [31:0]      beat_count,
  output logic [31:0]      stall_count,
`endif
  output logic             out_parity
);

  localparam int S1W = OP_W + 1 + 2 * WIDTH;
  localparam int S2W = WIDTH + 2;

  logic [S1W-1:0]   s1_in;
  logic [S1W-1:0]   s1_q;
  logic             s1_valid;
  logic             s2_ready;
  logic [S2W-1:0]   s2_in;
  logic [S2W-1:0]   s2_q;
  op_e              s1_op;
  logic             s1_acc;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] acc;
  logic             s2_load;

  assign s1_in = {in_op, in_acc, in_a, in_b};

  logic_unit_stage #(.W(S1W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  assign s1_op  = op_e'(s1_q[S1W-1 -: OP_W]);
  assign s1_acc = s1_q[2*WIDTH];
  assign s1_a   = s1_q[2*WIDTH-1:WIDTH];
  assign s1_b   = s1_q[WIDTH-1:0];
  assign opa    = s1_acc ? acc : s1_a;

  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = apply_op(s1_op, opa[i], s1_b[i]);
    end
  end

  assign s2_in   = {res, ~|res, ^res};
  assign s2_load = s1_valid & s2_ready;

  logic_unit_stage #(.W(S2W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign {out_result, out_zero, out_parity} = s2_q;

  // clear wins over a same-edge load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= ACC_RESET;
    end else if (acc_clr) begin
      acc <= ACC_RESET;
    end else if (s2_load) begin
      acc <= res;
    end
  end

`ifdef LOGIC_UNIT_PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count  <= '0;
      stall_count <= '0;
    end else begin
      if (out_valid & out_ready) begin
        beat_count <= beat_count + 32'd1;
      end
      if (out_valid & !out_ready) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe
// covers LOGIC_UNIT_PIPE_STATS_EN when defined
module tb_logic_unit_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = '0;
  logic         in_acc = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         acc_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_parity;
`ifdef LOGIC_UNIT_PIPE_STATS_EN
  logic [31:0]  beat_count;
  logic [31:0]  stall_count;
`endif

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_acc     (in_acc),
    .in_a       (in_a),
    .in_b       (in_b),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
`ifdef LOGIC_UNIT_PIPE_STATS_EN
    .beat_count (beat_count),
    .stall_count(stall_count),
`endif
    .out_parity (out_parity)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         p;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           check_lat = 0;
  bit           done = 0;
  logic [W-1:0] acc_m = '0;
  bit           held_v = 0;
  logic [W+1:0] held = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(
    int op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return ~(a & b);
      3: return ~(a | b);
      4: return a ^ b;
      5: return ~(a ^ b);
      6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // call between a rising edge and the following falling edge
  task automatic send(int op, bit acc,
                      logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    exp_t e;
    int t;
    t = 0;
    in_valid = 1'b1;
    in_op = op[2:0];
    in_acc = acc;
    in_a = a;
    in_b = b;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      r = ref_op(op, acc ? acc_m : a, b);
      acc_m = r;
      e.r = r;
      e.z = (r == '0);
      e.p = ^r;
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    sync();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      sync();
      t++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  task automatic clear_acc();
    drain();
    acc_clr = 1'b1;
    sync();
    acc_clr = 1'b0;
    acc_m = '0;
  endtask

  // monitor: pops and compares on every output handshake
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      held_v = 0;
    end else begin
      if (held_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data",
            32'({out_result, out_zero, out_parity}),
            32'(held));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", 32'(out_result), 32'(e.r));
          chk("zero", 32'(out_zero), 32'(e.z));
          chk("parity", 32'(out_parity), 32'(e.p));
          if (check_lat) begin
            chk("latency", 32'(cyc - e.cyc), 32'd1);
          end
        end
      end
      held_v = out_valid && !out_ready;
      held = {out_result, out_zero, out_parity};
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(out_result), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    chk("rst_parity", 32'(out_parity), 32'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    sync();

    // op sweep and zero flag, latency checked
    check_lat = 1;
    for (int op = 0; op < 8; op++) send(op, 0, 8'hF0, 8'hCC);
    send(0, 0, 8'hAA, 8'h55);
    drain();
    check_lat = 0;

    // backpressure: two beats fill the pipe
    out_ready = 1'b0;
    send(1, 0, 8'h11, 8'h22);
    send(4, 0, 8'h33, 8'h44);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    fork
      begin
        sync();
        send(2, 0, 8'h5A, 8'h0F);
        send(7, 0, 8'h81, 8'h00);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // accumulate chain and clear precedence
    clear_acc();
    send(1, 1, 8'h5A, 8'h01);
    send(1, 1, 8'hA5, 8'h02);
    send(1, 1, 8'h3C, 8'h04);
    send(4, 1, 8'h00, 8'hFF);
    acc_clr = 1'b1;
    sync();
    acc_clr = 1'b0;
    acc_m = '0;
    send(1, 1, 8'h77, 8'h10);
    drain();

    // async reset with the pipe full
    out_ready = 1'b0;
    send(0, 0, 8'hFF, 8'h0F);
    send(5, 1, 8'h12, 8'h34);
    sync();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    q.delete();
    acc_m = '0;
    @(negedge clk);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    sync();
    send(1, 1, 8'hA5, 8'h00);
    drain();

    // randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int n;
          if ($urandom_range(0, 19) == 0) clear_acc();
          n = $urandom_range(0, 2);
          repeat (n) sync();
          send($urandom_range(0, 7), 1'($urandom_range(0, 1)),
               W'($urandom), W'($urandom));
        end
        done = 1;
      end
      begin
        while (!done) begin
          sync();
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

`ifdef LOGIC_UNIT_PIPE_STATS_EN
    rst_n = 1'b0;
    q.delete();
    acc_m = '0;
    sync();
    rst_n = 1'b1;
    sync();
    fork
      for (int i = 0; i < 10; i++)
        send(i % 8, 0, W'($urandom), W'($urandom));
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("beat_count", beat_count, 32'd10);
    chk("stall_count", stall_count, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
